preg_free_list: RTL

- Circular free list of physical register tags for the rename stage of the 6502 out-of-order core.
- Each cycle the decoder may allocate up to ALLOC_WIDTH fresh destination tags, one per renamed micro-op slot.
- Each cycle the completion/retire path may return up to FREE_WIDTH tags.
- The block arbitrates the shared physical-register pool. It grants a decode group all-or-nothing, so a partially renamed group never exists.

---
 rtl/preg_free_list_pkg.sv | 27 ++
 rtl/mask_prefix_count.sv | 24 ++
 rtl/preg_free_list.sv | 138 +++++++++++++
 3 files changed

// File: rtl/preg_free_list_pkg.sv
// Shared rename-stage constants used by the decoder, the ROB and the physical register free list.
`define PREG_TAG_SLOT(vec, k, bits) vec[(k)*(bits) +: (bits)]

package preg_free_list_pkg;

    localparam int PREG_BITS   = 6;
    localparam int NUM_PREGS   = 64;
    localparam int NUM_ARCH    = 8;
    localparam int FETCH_WIDTH = 4;
    localparam int ALLOC_WIDTH = FETCH_WIDTH;
    localparam int FREE_WIDTH  = 5;

    typedef logic [PREG_BITS-1:0] preg_tag_t;
    typedef logic [PREG_BITS:0]   preg_count_t;

    // Reset contents of free-list entry i: the non-architectural tags in ascending order.
    function automatic int init_tag(input int i, input int num_arch, input int num_pregs);
        int tag_v;
        if (i < num_pregs - num_arch) begin
            tag_v = num_arch + i;
        end else begin
            tag_v = 0;
        end
        return tag_v;
    endfunction

endpackage

// File: rtl/mask_prefix_count.sv
// Population count of a slot mask plus the exclusive prefix count seen by every slot.
module mask_prefix_count #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         mask,
    output logic [CW-1:0]        total,
    output logic [W-1:0][CW-1:0] prefix
);

    logic [CW-1:0] acc_s;

    // Ripple a running count through the mask; slot i only sees bits below it.
    always_comb begin
        acc_s  = '0;
        prefix = '0;
        for (int i = 0; i < W; i++) begin
            prefix[i] = acc_s;
            acc_s     = acc_s + CW'(mask[i]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags: all-or-nothing group allocation, compacted release.
module preg_free_list #(
    parameter int PREG_BITS   = preg_free_list_pkg::PREG_BITS,
    parameter int NUM_PREGS   = preg_free_list_pkg::NUM_PREGS,
    parameter int NUM_ARCH    = preg_free_list_pkg::NUM_ARCH,
    parameter int ALLOC_WIDTH = preg_free_list_pkg::ALLOC_WIDTH,
    parameter int FREE_WIDTH  = preg_free_list_pkg::FREE_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ALLOC_WIDTH-1:0]           alloc_req,
    input  logic                             alloc_valid,
    output logic                             alloc_ready,
    output logic [ALLOC_WIDTH*PREG_BITS-1:0] alloc_tags,
    input  logic [FREE_WIDTH-1:0]            free_valid,
    input  logic [FREE_WIDTH*PREG_BITS-1:0]  free_tags,
    output logic [PREG_BITS:0]               free_count,
    output logic                             empty,
    output logic                             overflow_err
);

    import preg_free_list_pkg::*;

    localparam int ACW   = $clog2(ALLOC_WIDTH + 1);
    localparam int FCW   = $clog2(FREE_WIDTH + 1);
    localparam int CNT_W = PREG_BITS + 1;
    localparam int SUM_W = PREG_BITS + 2;

    logic [PREG_BITS-1:0]            tag_mem_r [NUM_PREGS];
    logic [PREG_BITS-1:0]            head_r;
    logic [PREG_BITS-1:0]            tail_r;
    logic [CNT_W-1:0]                count_r;
    logic                            empty_r;
    logic                            overflow_r;

    logic [ACW-1:0]                  need_s;
    logic [ALLOC_WIDTH-1:0][ACW-1:0] alloc_prefix_s;
    logic [FCW-1:0]                  nfree_s;
    logic [FREE_WIDTH-1:0][FCW-1:0]  free_prefix_s;

    logic                            fire_s;
    logic [CNT_W-1:0]                consumed_s;
    logic [SUM_W-1:0]                sum_s;
    logic                            release_ok_s;
    logic [CNT_W-1:0]                count_next_s;
    logic [PREG_BITS-1:0]            head_next_s;
    logic [PREG_BITS-1:0]            tail_next_s;

    mask_prefix_count #(
        .W  (ALLOC_WIDTH),
        .CW (ACW)
    ) u_alloc_count (
        .mask   (alloc_req),
        .total  (need_s),
        .prefix (alloc_prefix_s)
    );

    mask_prefix_count #(
        .W  (FREE_WIDTH),
        .CW (FCW)
    ) u_free_count (
        .mask   (free_valid),
        .total  (nfree_s),
        .prefix (free_prefix_s)
    );

    // Grant decision and next pointer/count; freed tags never feed this cycle's grant.
    always_comb begin
        alloc_ready  = (count_r >= CNT_W'(need_s));
        fire_s       = alloc_valid & alloc_ready & (need_s != '0);
        consumed_s   = '0;
        sum_s        = '0;
        release_ok_s = 1'b1;
        count_next_s = count_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        if (fire_s) begin
            consumed_s = CNT_W'(need_s);
        end else begin
            consumed_s = '0;
        end
        head_next_s  = head_r + PREG_BITS'(consumed_s);
        sum_s        = SUM_W'(count_r) - SUM_W'(consumed_s) + SUM_W'(nfree_s);
        release_ok_s = (sum_s <= SUM_W'(NUM_PREGS));
        if (release_ok_s) begin
            count_next_s = sum_s[CNT_W-1:0];
            tail_next_s  = tail_r + PREG_BITS'(nfree_s);
        end else begin
            count_next_s = count_r - consumed_s;
            tail_next_s  = tail_r;
        end
    end

    // Each requested slot reads the entry offset from head by the number of lower requested slots.
    always_comb begin
        alloc_tags = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            `PREG_TAG_SLOT(alloc_tags, k, PREG_BITS) = tag_mem_r[head_r + PREG_BITS'(alloc_prefix_s[k])];
        end
    end

    // Tag storage: reset seeds the non-architectural tags, releases are compacted at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                tag_mem_r[i] <= PREG_BITS'(init_tag(i, NUM_ARCH, NUM_PREGS));
            end
        end else if (release_ok_s) begin
            for (int j = 0; j < FREE_WIDTH; j++) begin
                if (free_valid[j]) begin
                    tag_mem_r[tail_r + PREG_BITS'(free_prefix_s[j])] <= `PREG_TAG_SLOT(free_tags, j, PREG_BITS);
                end
            end
        end
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r     <= '0;
            tail_r     <= PREG_BITS'(NUM_PREGS - NUM_ARCH);
            count_r    <= CNT_W'(NUM_PREGS - NUM_ARCH);
            empty_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == '0);
            overflow_r <= overflow_r | ~release_ok_s;
        end
    end

    assign free_count   = count_r;
    assign empty        = empty_r;
    assign overflow_err = overflow_r;

endmodule
